bnn_fc_layer_seq: RTL and testbench
===================================

Name: bnn_fc_layer_seq

Overview:
- Time-multiplexed, parametrised binary fully-connected layer.
- Each input pixel is thermometer-binarised into CH_CNT channels. Each channel is XNORed with a stored 1-bit weight, and the results are popcount-accumulated per neuron.
- LANES neurons are computed per clock over OUT_DIM/LANES cycles, behind valid/ready handshakes.
- Sits between the pixel source and the next layer. Replaces the fully-combinational layer where area matters.

Parameters:
IN_DIM, 16, input pixels per vector
IN_BIT, 4, bits per input pixel and per output value
CH_CNT, 4, binarisation channels per pixel; power of two, 2 <= CH_CNT <= 2^(IN_BIT-1)
OUT_DIM, 8, neurons (outputs) per vector
LANES, 2, neurons computed per clock; must divide OUT_DIM
OUT_SHIFT, 1, arithmetic right shift applied to each neuron sum before saturation

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  value_in is valid
in_ready  output  1  block accepts a vector (high only in IDLE)
value_in  input  IN_DIM*IN_BIT  packed unsigned pixels, pixel j at [j*IN_BIT +: IN_BIT]
w_we  input  1  weight row write strobe
w_addr  input  clog2(OUT_DIM)  neuron row index
w_data  input  IN_DIM  weight row, bit j = weight for pixel j (1 = +1, 0 = -1)
w_ready  output  1  weight write accepted this cycle (high only in IDLE)
out_valid  output  1  value_out holds a complete result vector
out_ready  input  1  consumer accepts value_out
value_out  output  OUT_DIM*IN_BIT  packed results, neuron i at [i*IN_BIT +: IN_BIT]

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, rst.
- Reset values: state = IDLE, in_ready = 1, w_ready = 1, out_valid = 0, value_out = 0, weight array = 0, group counter = 0.
- Binarisation: STEP = 2^IN_BIT / CH_CNT. Channel k of pixel j = (value_in[j] >= k*STEP + STEP/2). The result is registered on the input handshake edge.
- Per pixel term: p = popcount(channels XNOR {CH_CNT{w[i][j]}}); term = 2p - CH_CNT, signed.
- Neuron sum: S = sum over j of the terms. ACC_W = clog2(IN_DIM*CH_CNT) + 2, so no overflow is possible.
- Output: S >>> OUT_SHIFT (floor), then saturated as defined under Optional Feature.
- FSM states IDLE, COMPUTE, DONE.
- IDLE:
  - in_valid & in_ready captures the binarised vector, clears the group counter and moves to COMPUTE.
  - w_we writes row w_addr. w_addr >= OUT_DIM is ignored.
- COMPUTE:
  - Each clock writes neurons g*LANES .. g*LANES+LANES-1 of value_out, then increments g.
  - After group N-1 (N = OUT_DIM/LANES), moves to DONE.
  - w_we is dropped (w_ready = 0). in_ready = 0.
- DONE:
  - out_valid = 1; value_out is stable.
  - out_valid & out_ready moves to IDLE. out_valid falls on the same edge.
- Latency: out_valid is high N clocks after the input handshake edge. Throughput is one vector per N+2 clocks with out_ready held high.
- value_out keeps its last result after the DONE handshake, until overwritten group by group.
- Simultaneous in_valid and w_we in IDLE: both are accepted. The captured vector is computed with the weights as they stand after that edge, including the new row.
- in_valid is ignored outside IDLE. Inputs are sampled only on the handshake edge.
- out_ready is ignored outside DONE.
- rst mid-COMPUTE or mid-DONE: the result is discarded, all reset values apply immediately, and the weights are cleared.

Optional Feature:
- Macro BNN_RELU_EN.
- Defined: value_out is unsigned. Shifted sums below 0 clamp to 0, and sums above 2^IN_BIT-1 clamp to 2^IN_BIT-1.
- Undefined: value_out is signed two's complement, saturated to [-2^(IN_BIT-1), 2^(IN_BIT-1)-1].

Test Plan:
All tests use the defaults with IN_DIM=4, OUT_DIM=4, LANES=2 (STEP=4, thresholds 2,6,10,14).
- All weights 1, all pixels 15 -> S=16, shifted 8. value_out neurons = 7 (signed) or 8 (BNN_RELU_EN). out_valid rises exactly 2 clocks after the handshake.
- All weights 0, all pixels 15 -> S=-16, shifted -8. Outputs 0x8 (signed) or 0 (RELU).
- Weights all 0, pixels all 0 -> channels 0000, XNOR gives all 1s, S=+16. Outputs 7 (signed) or 8 (RELU).
- Row 2 = 4'b0101, pixels {15,0,15,0} -> every term -4, S=-16, neuron 2 = 0x8 (signed). Other rows at 0 give S=0, output 0.
- Hold out_ready=0 for 5 clocks in DONE -> out_valid and value_out stable, in_ready=0, w_we dropped. out_ready=1 -> IDLE next clock.
- Assert rst mid-COMPUTE -> out_valid=0, value_out=0, in_ready=1 immediately. Then with no weight reload, all pixels 15 -> every neuron S=-16, output 0x8 (signed).

Source files
------------

// File: rtl/bnn_fc_layer_seq.sv
// -----------------------------------------------------------------------------
// bnn_fc_layer_seq
//
// Time-multiplexed binary fully-connected layer. An input vector of IN_DIM
// unsigned pixels is thermometer-binarised into CH_CNT channels per pixel and
// captured on the input handshake. Each neuron's 1-bit weight per pixel is
// XNORed with every channel of that pixel. The matches are accumulated as a
// signed sum of (2*popcount - CH_CNT) terms. The sum is arithmetically shifted
// right by OUT_SHIFT and then saturated. LANES neurons are produced per clock,
// so a full vector takes OUT_DIM/LANES clocks.
//
// Optional feature macro: BNN_RELU_EN
//   defined   : outputs are unsigned and clamped to [0, 2^IN_BIT-1]
//   undefined : outputs are signed and clamped to
//               [-2^(IN_BIT-1), 2^(IN_BIT-1)-1]
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input vector handshake (in_ready high only in IDLE)
//   value_in              packed pixels, pixel j at [j*IN_BIT +: IN_BIT]
//   w_we, w_addr, w_data  weight row write (bit j = weight for pixel j)
//   w_ready               weight write accepted (high only in IDLE)
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   value_out             packed results, neuron i at [i*IN_BIT +: IN_BIT]
// -----------------------------------------------------------------------------
module bnn_fc_layer_seq #(
    parameter int IN_DIM    = 16,
    parameter int IN_BIT    = 4,
    parameter int CH_CNT    = 4,
    parameter int OUT_DIM   = 8,
    parameter int LANES     = 2,
    parameter int OUT_SHIFT = 1,
    localparam int AW       = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_DIM*IN_BIT-1:0]  value_in,
    input  logic                      w_we,
    input  logic [AW-1:0]             w_addr,
    input  logic [IN_DIM-1:0]         w_data,
    output logic                      w_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_DIM*IN_BIT-1:0] value_out
);

    localparam int STEP  = (2 ** IN_BIT) / CH_CNT;
    localparam int ACC_W = $clog2(IN_DIM * CH_CNT) + 2;
    // Comparison width wide enough for both the accumulator and the clamp limits.
    localparam int CMP_W = (ACC_W > IN_BIT + 2) ? ACC_W : IN_BIT + 2;
    localparam int N_GRP = OUT_DIM / LANES;
    localparam int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1;

`ifdef BNN_RELU_EN
    localparam logic signed [CMP_W-1:0] SAT_LO = '0;
    localparam logic signed [CMP_W-1:0] SAT_HI = CMP_W'((2 ** IN_BIT) - 1);
`else
    localparam logic signed [CMP_W-1:0] SAT_LO = CMP_W'(-(2 ** (IN_BIT - 1)));
    localparam logic signed [CMP_W-1:0] SAT_HI = CMP_W'((2 ** (IN_BIT - 1)) - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [GW-1:0]               grp_q, grp_d;
    logic [IN_DIM*CH_CNT-1:0]    ch_q, ch_d;
    logic [OUT_DIM*IN_BIT-1:0]   value_out_q, value_out_d;
    logic                        in_ready_q, in_ready_d;
    logic                        w_ready_q, w_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic [IN_DIM-1:0]           w_mem_q [OUT_DIM];
    logic                        w_wr_en;

    logic [IN_DIM*CH_CNT-1:0]    ch_bin;
    logic [LANES*IN_BIT-1:0]     lane_flat;

    // -------------------------------------------------------------------------
    // Thermometer binarisation: channel k fires when the pixel reaches the
    // midpoint of the k-th STEP-wide bin. The compare is done one bit wider so
    // that a threshold can never wrap.
    // -------------------------------------------------------------------------
    genvar gi, gk;
    generate
        for (gi = 0; gi < IN_DIM; gi++) begin : g_bin_pix
            for (gk = 0; gk < CH_CNT; gk++) begin : g_bin_ch
                localparam logic [IN_BIT:0] THR = (IN_BIT + 1)'(gk * STEP + STEP / 2);
                assign ch_bin[gi*CH_CNT + gk] =
                    ({1'b0, value_in[gi*IN_BIT +: IN_BIT]} >= THR);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Neuron lanes: lane gi evaluates neuron grp_q*LANES + gi from the captured
    // channels and the current contents of its weight row.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [AW-1:0]            row_idx;
            logic [IN_DIM-1:0]        row;
            logic signed [ACC_W-1:0]  sum;
            logic signed [CMP_W-1:0]  shifted;
            logic [IN_BIT-1:0]        lane_res;
            int                       p;

            always_comb begin
                row_idx = AW'(int'(grp_q) * LANES + gi);
                row     = w_mem_q[row_idx];
                sum     = '0;
                p       = 0;
                for (int j = 0; j < IN_DIM; j++) begin
                    // XNOR match count between channels and the pixel's weight bit
                    p = 0;
                    for (int k = 0; k < CH_CNT; k++) begin
                        if (ch_q[j*CH_CNT + k] == row[j]) begin
                            p = p + 1;
                        end
                    end
                    sum = sum + ACC_W'(2 * p - CH_CNT);
                end
                // Sign-extend first so the arithmetic shift floors negative sums.
                shifted = CMP_W'(sum) >>> OUT_SHIFT;
                if (shifted < SAT_LO) begin
                    lane_res = SAT_LO[IN_BIT-1:0];
                end else if (shifted > SAT_HI) begin
                    lane_res = SAT_HI[IN_BIT-1:0];
                end else begin
                    lane_res = shifted[IN_BIT-1:0];
                end
            end

            assign lane_flat[gi*IN_BIT +: IN_BIT] = lane_res;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        ch_d        = ch_q;
        value_out_d = value_out_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ch_d    = ch_bin;
                    grp_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    value_out_d[(int'(grp_q) * LANES + l) * IN_BIT +: IN_BIT] =
                        lane_flat[l*IN_BIT +: IN_BIT];
                end
                if (grp_q == GW'(N_GRP - 1)) begin
                    state_d = S_DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state decode.
        in_ready_d  = (state_d == S_IDLE);
        w_ready_d   = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // Writes land in IDLE only; a row written alongside an accepted vector is
    // already visible when COMPUTE starts reading on the following clock.
    assign w_wr_en = w_we && (state_q == S_IDLE) && (int'(w_addr) < OUT_DIM);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grp_q       <= '0;
            ch_q        <= '0;
            value_out_q <= '0;
            in_ready_q  <= 1'b1;
            w_ready_q   <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            ch_q        <= ch_d;
            value_out_q <= value_out_d;
            in_ready_q  <= in_ready_d;
            w_ready_q   <= w_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Weight rows are cleared by reset, so they live in flops rather than RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_DIM; i++) begin
                w_mem_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            w_mem_q[w_addr] <= w_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign w_ready   = w_ready_q;
    assign out_valid = out_valid_q;
    assign value_out = value_out_q;

endmodule

// File: tb/tb_bnn_fc_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_bnn_fc_layer_seq
//
// Directed bench for bnn_fc_layer_seq with IN_DIM=4, OUT_DIM=4, LANES=2,
// IN_BIT=4, CH_CNT=4, OUT_SHIFT=1 (thresholds 2,6,10,14). Expected neuron
// values are hand-computed; the signed/unsigned variants follow BNN_RELU_EN.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bnn_fc_layer_seq;

    localparam int IN_DIM  = 4;
    localparam int IN_BIT  = 4;
    localparam int OUT_DIM = 4;

`ifdef BNN_RELU_EN
    localparam logic [3:0] P16 = 4'd8;   // S=+16
    localparam logic [3:0] M16 = 4'd0;   // S=-16
    localparam logic [3:0] M2  = 4'd0;   // S=-2
`else
    localparam logic [3:0] P16 = 4'd7;
    localparam logic [3:0] M16 = 4'h8;
    localparam logic [3:0] M2  = 4'hF;
`endif
    localparam logic [3:0] P8  = 4'd4;   // S=+8
    localparam logic [3:0] Z0  = 4'd0;   // S=0

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_DIM*IN_BIT-1:0]  value_in;
    logic                      w_we;
    logic [1:0]                w_addr;
    logic [IN_DIM-1:0]         w_data;
    logic                      w_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_DIM*IN_BIT-1:0] value_out;

    int n_checks = 0;
    int n_pass   = 0;

    bnn_fc_layer_seq #(
        .IN_DIM   (IN_DIM),
        .IN_BIT   (IN_BIT),
        .CH_CNT   (4),
        .OUT_DIM  (OUT_DIM),
        .LANES    (2),
        .OUT_SHIFT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .value_in (value_in),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_ready  (w_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .value_out(value_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic write_row(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = a;
        w_data = d;
        @(negedge clk);
        w_we   = 1'b0;
    endtask

    // One full vector: handshake, latency checks, per-neuron results, optional
    // DONE hold (with an attempted weight write), then the output handshake.
    task automatic run_vec(input string tag, input logic [15:0] pix, input logic [15:0] exp,
                           input int hold, input logic wr, input logic [1:0] wa,
                           input logic [3:0] wd);
        @(negedge clk);
        check({tag, ".in_ready"}, {15'd0, in_ready}, 16'd1);
        value_in = pix;
        in_valid = 1'b1;
        w_we     = wr;
        w_addr   = wa;
        w_data   = wd;
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
        value_in = ~pix;     // must not matter after the handshake
        check({tag, ".lat0"}, {15'd0, out_valid}, 16'd0);
        check({tag, ".busy"}, {14'd0, in_ready, w_ready}, 16'd0);
        @(negedge clk);
        check({tag, ".lat1"}, {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        check({tag, ".lat2"}, {15'd0, out_valid}, 16'd1);
        for (int i = 0; i < OUT_DIM; i++) begin
            check($sformatf("%s.n%0d", tag, i), {12'd0, value_out[i*4 +: 4]}, {12'd0, exp[i*4 +: 4]});
        end
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                w_we   = 1'b1;
                w_addr = 2'd0;
                w_data = 4'hF;
            end
            @(negedge clk);
            w_we = 1'b0;
            check($sformatf("%s.hold%0d", tag, h),
                  {out_valid, in_ready, w_ready, 13'd0}, 16'h8000);
            check($sformatf("%s.hold%0d.val", tag, h), value_out, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".release"}, {14'd0, out_valid, in_ready}, 16'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        value_in  = '0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.flags", {13'd0, in_ready, w_ready, out_valid}, 16'b110);
        check("reset.value_out", value_out, 16'h0000);
        rst = 1'b0;

        // All weights +1
        for (int r = 0; r < 4; r++) write_row(2'(r), 4'hF);
        run_vec("w1_px15", 16'hFFFF, {P16, P16, P16, P16}, 0, 1'b0, 2'd0, 4'h0);
        // Pixels 13,13,13,10 -> +2 each, S=8 -> 4
        run_vec("w1_px13", 16'hDDDA, {P8, P8, P8, P8}, 0, 1'b0, 2'd0, 4'h0);
        // Threshold edges: 6->0, 1->-4, 2->-2, 14->+4, S=-2 -> -1
        run_vec("w1_edge", 16'hE216, {M2, M2, M2, M2}, 0, 1'b0, 2'd0, 4'h0);

        // All weights -1
        for (int r = 0; r < 4; r++) write_row(2'(r), 4'h0);
        run_vec("w0_px15", 16'hFFFF, {M16, M16, M16, M16}, 0, 1'b0, 2'd0, 4'h0);
        run_vec("w0_px0", 16'h0000, {P16, P16, P16, P16}, 0, 1'b0, 2'd0, 4'h0);

        // Row 2 = 0101 against pixels {15,0,15,0}
        write_row(2'd2, 4'b0101);
        run_vec("row2", 16'hF0F0, {Z0, M16, Z0, Z0}, 0, 1'b0, 2'd0, 4'h0);

        // Write row 1 on the same edge as the vector handshake
        run_vec("simul", 16'hFFFF, {M16, Z0, P16, M16}, 0, 1'b1, 2'd1, 4'hF);

        // Hold DONE for 5 clocks; the write attempted there must be dropped
        run_vec("hold", 16'hFFFF, {M16, Z0, P16, M16}, 5, 1'b0, 2'd0, 4'h0);
        run_vec("after_hold", 16'hFFFF, {M16, Z0, P16, M16}, 0, 1'b0, 2'd0, 4'h0);

        // Reset mid-COMPUTE
        @(negedge clk);
        value_in = 16'hFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst.flags", {13'd0, in_ready, w_ready, out_valid}, 16'b110);
        check("midrst.value_out", value_out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        run_vec("post_rst", 16'hFFFF, {M16, M16, M16, M16}, 0, 1'b0, 2'd0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
